lsu: RTL and testbench

// Load/store response stage directly downstream of the execute unit. Captures the EXU->LSU bus,

---
 rtl/lsu.sv | 138 +++++++++++++
 tb/tb_lsu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store response stage: captures the EXU bus, finishes the AXI R/B handshake,
// aligns/extends load data and emits a one-cycle-valid LSU->WBU bus. Memory waits are time-bounded.
module lsu #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         exu_valid_i,
  input  logic [126:0] exu_lsu_bus_i,
  input  logic         rvalid_i,
  input  logic [31:0]  rdata_i,
  input  logic [1:0]   rresp_i,
  output logic         rready_o,
  input  logic         bvalid_i,
  input  logic [1:0]   bresp_i,
  output logic         bready_o,
  output logic [119:0] lsu_wbu_bus_o,
  output logic         valid_o,
  output logic         overrun_o
);

  typedef enum logic [1:0] {IDLE, WAIT_R, WAIT_B} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [126:0]   op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic           overrun_q, overrun_d;
  logic [119:0]   bus_q, bus_d;

  logic [4:0]     shamt;
  logic [31:0]    word_sh;
  logic [31:0]    load_val;
  logic           timeout_hit;

  // A fault suppresses both architectural write enables; all other fields pass through.
  function automatic logic [119:0] pack(input logic [126:0] op, input logic fault,
                                        input logic [31:0] res);
    return {op[126:95], op[94] & ~fault, op[86:75], op[73] & ~fault, op[72:68],
            op[67], op[66], op[65], op[64], op[63:32], res, fault};
  endfunction

  always_comb begin
    shamt   = {op_q[93:92], 3'b000};
    word_sh = rdata_i >> shamt;
    case (op_q[91:88])
      4'b0011: load_val = {{16{word_sh[15]}}, word_sh[15:0]};
      4'b0111: load_val = {16'h0000, word_sh[15:0]};
      4'b0001: load_val = {{24{word_sh[7]}}, word_sh[7:0]};
      4'b0101: load_val = {24'h000000, word_sh[7:0]};
      default: load_val = word_sh;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign rready_o    = (state_q == WAIT_R);
  assign bready_o    = (state_q == WAIT_B);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    bus_d     = bus_q;
    if (exu_valid_i && state_q != IDLE) overrun_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (exu_valid_i) begin
          op_d  = exu_lsu_bus_i;
          cnt_d = '0;
          if (|exu_lsu_bus_i[91:88]) begin
            state_d = WAIT_R;
          end else if (exu_lsu_bus_i[87]) begin
            state_d = WAIT_B;
          end else begin
            valid_d = 1'b1;
            bus_d   = pack(exu_lsu_bus_i, 1'b0, exu_lsu_bus_i[31:0]);
          end
        end
      end
      WAIT_R: begin
        // A response in the timeout cycle takes priority over the timeout.
        if (rvalid_i) begin
          state_d = IDLE;
          valid_d = 1'b1;
          bus_d   = pack(op_q, |rresp_i, op_q[74] ? load_val : op_q[31:0]);
        end else if (timeout_hit) begin
          state_d = IDLE;
          valid_d = 1'b1;
          bus_d   = pack(op_q, 1'b1, op_q[31:0]);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_B: begin
        if (bvalid_i) begin
          state_d = IDLE;
          valid_d = 1'b1;
          bus_d   = pack(op_q, |bresp_i, op_q[31:0]);
        end else if (timeout_hit) begin
          state_d = IDLE;
          valid_d = 1'b1;
          bus_d   = pack(op_q, 1'b1, op_q[31:0]);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      bus_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      bus_q     <= bus_d;
    end
  end

  assign lsu_wbu_bus_o = bus_q;
  assign valid_o       = valid_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, non-memory ops, bus errors, timeout, overrun and mid-wait reset.
module tb_lsu;

  logic         clock = 1'b0;
  logic         reset;
  logic         exu_valid_i;
  logic [126:0] exu_lsu_bus_i;
  logic         rvalid_i;
  logic [31:0]  rdata_i;
  logic [1:0]   rresp_i;
  logic         rready_o;
  logic         bvalid_i;
  logic [1:0]   bresp_i;
  logic         bready_o;
  logic [119:0] lsu_wbu_bus_o;
  logic         valid_o;
  logic         overrun_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  lsu #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .exu_valid_i   (exu_valid_i),
    .exu_lsu_bus_i (exu_lsu_bus_i),
    .rvalid_i      (rvalid_i),
    .rdata_i       (rdata_i),
    .rresp_i       (rresp_i),
    .rready_o      (rready_o),
    .bvalid_i      (bvalid_i),
    .bresp_i       (bresp_i),
    .bready_o      (bready_o),
    .lsu_wbu_bus_o (lsu_wbu_bus_o),
    .valid_o       (valid_o),
    .overrun_o     (overrun_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [126:0] mk(input logic csr_we, input logic [1:0] mask,
                                      input logic [3:0] re, input logic we, input logic rfm,
                                      input logic gr_we, input logic [31:0] res);
    return {32'hC5C5_0001, csr_we, mask, re, we, 12'h345, rfm, gr_we, 5'd7,
            4'b0000, 32'h8000_1234, res};
  endfunction

  task automatic issue(input logic [126:0] b);
    exu_lsu_bus_i = b;
    exu_valid_i   = 1'b1;
    tick();
    exu_valid_i   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; exu_valid_i = 1'b0; exu_lsu_bus_i = '0;
    rvalid_i = 1'b0; rdata_i = '0; rresp_i = '0; bvalid_i = 1'b0; bresp_i = '0;
    tick(); tick();
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_bus", lsu_wbu_bus_o, 120'h0);
    chk("rst_ready", {rready_o, bready_o, overrun_o}, 3'b000);
    reset = 1'b1;
    tick();

    // non-memory op
    issue(mk(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF));
    chk("alu_valid", valid_o, 1'b1);
    chk("alu_result", lsu_wbu_bus_o[32:1], 32'hDEADBEEF);
    chk("alu_jt", lsu_wbu_bus_o[64:33], 32'h8000_1234);
    chk("alu_grwe", lsu_wbu_bus_o[74], 1'b1);
    chk("alu_rd", lsu_wbu_bus_o[73:69], 5'd7);
    chk("alu_ready", {rready_o, bready_o}, 2'b00);
    tick();
    chk("alu_pulse", valid_o, 1'b0);
    chk("alu_hold", lsu_wbu_bus_o[32:1], 32'hDEADBEEF);

    // lb, byte lane 2, response two cycles late
    rdata_i = 32'h12803456;
    issue(mk(1'b0, 2'b10, 4'b0001, 1'b0, 1'b1, 1'b1, 32'h0000_1002));
    for (int i = 0; i < 2; i++) begin
      chk("lb_rready", rready_o, 1'b1);
      chk("lb_wait", valid_o, 1'b0);
      tick();
    end
    rvalid_i = 1'b1;
    tick();
    rvalid_i = 1'b0;
    chk("lb_valid", valid_o, 1'b1);
    chk("lb_result", lsu_wbu_bus_o[32:1], 32'hFFFFFF80);
    chk("lb_fault", lsu_wbu_bus_o[0], 1'b0);
    chk("lb_rready_off", rready_o, 1'b0);
    tick();
    chk("lb_pulse", valid_o, 1'b0);

    // lhu with R already valid before entry
    rdata_i = 32'hBEEF1234; rvalid_i = 1'b1;
    chk("lhu_idle_rready", rready_o, 1'b0);
    issue(mk(1'b0, 2'b10, 4'b0111, 1'b0, 1'b1, 1'b1, 32'h0000_2002));
    chk("lhu_early", valid_o, 1'b0);
    tick();
    rvalid_i = 1'b0;
    chk("lhu_valid", valid_o, 1'b1);
    chk("lhu_result", lsu_wbu_bus_o[32:1], 32'h0000BEEF);
    tick();

    // sw, B response three cycles late
    issue(mk(1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h11223344));
    for (int i = 0; i < 3; i++) begin
      chk("sw_bready", bready_o, 1'b1);
      chk("sw_wait", valid_o, 1'b0);
      tick();
    end
    bvalid_i = 1'b1;
    tick();
    bvalid_i = 1'b0;
    chk("sw_valid", valid_o, 1'b1);
    chk("sw_result", lsu_wbu_bus_o[32:1], 32'h11223344);
    chk("sw_fault", lsu_wbu_bus_o[0], 1'b0);
    chk("sw_bready_off", bready_o, 1'b0);
    tick();
    chk("sw_pulse", valid_o, 1'b0);

    // lw with SLVERR
    rdata_i = 32'h0BAD_0BAD; rresp_i = 2'b10; rvalid_i = 1'b1;
    issue(mk(1'b1, 2'b00, 4'b1111, 1'b0, 1'b1, 1'b1, 32'h0000_3000));
    tick();
    rvalid_i = 1'b0; rresp_i = 2'b00;
    chk("lwerr_valid", valid_o, 1'b1);
    chk("lwerr_fault", lsu_wbu_bus_o[0], 1'b1);
    chk("lwerr_grwe", lsu_wbu_bus_o[74], 1'b0);
    chk("lwerr_csrwe", lsu_wbu_bus_o[87], 1'b0);
    chk("lwerr_csraddr", lsu_wbu_bus_o[86:75], 12'h345);
    tick();

    // store timeout: no B response at all
    issue(mk(1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h5555_0000));
    for (int i = 0; i < 8; i++) begin
      chk("to_wait", valid_o, 1'b0);
      tick();
    end
    chk("to_valid", valid_o, 1'b1);
    chk("to_fault", lsu_wbu_bus_o[0], 1'b1);
    chk("to_result", lsu_wbu_bus_o[32:1], 32'h5555_0000);
    tick();
    chk("to_pulse", {valid_o, bready_o}, 2'b00);

    // second op arrives during WAIT_B
    issue(mk(1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 32'hAAAA5555));
    chk("ovr_before", overrun_o, 1'b0);
    issue(mk(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h12345678));
    chk("ovr_set", overrun_o, 1'b1);
    chk("ovr_novalid", valid_o, 1'b0);
    chk("ovr_bready", bready_o, 1'b1);
    bvalid_i = 1'b1;
    tick();
    bvalid_i = 1'b0;
    chk("ovr_valid", valid_o, 1'b1);
    chk("ovr_result", lsu_wbu_bus_o[32:1], 32'hAAAA5555);
    chk("ovr_grwe", lsu_wbu_bus_o[74], 1'b0);
    tick();
    chk("ovr_single", valid_o, 1'b0);
    chk("ovr_sticky", overrun_o, 1'b1);

    // reset in the middle of WAIT_R
    issue(mk(1'b0, 2'b00, 4'b1111, 1'b0, 1'b1, 1'b1, 32'h0000_4000));
    tick();
    chk("mid_rready", rready_o, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_rready", rready_o, 1'b0);
    chk("mid_rst_bus", lsu_wbu_bus_o, 120'h0);
    chk("mid_rst_flags", {valid_o, overrun_o}, 2'b00);
    #2;
    reset = 1'b1;
    rvalid_i = 1'b1;
    tick();
    chk("mid_after_valid", valid_o, 1'b0);
    chk("mid_after_rready", rready_o, 1'b0);
    tick();
    chk("mid_after_valid2", valid_o, 1'b0);
    rvalid_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
